stack_unit: RTL and testbench

Synchronous LIFO storage that serves as the responder side of the stack computer's push/pop interface. The datapath drives `push`, `pop` and `stack_in`. This block stores operands and returns the registered top-of-stack value, the second element, occupancy and an error flag. It sits between the instruction sequencer and the seven-segment display path, which reads `top`.

---
 rtl/stack_unit.sv | 123 ++++++++++++
 tb/tb_stack_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// stack_unit: synchronous LIFO with registered top/second/count/flags.
// Ports: clk, reset (sync, active-low), push, pop, stack_in -> top, second,
//   count, empty, full, error. Macro STACK_STICKY_ERROR_EN latches error.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] stack_in,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] top_q, second_q;
  logic [CW-1:0]    count_q;
  logic             empty_q, full_q, error_q;

  logic [WIDTH-1:0] n_top, n_second;
  logic [CW-1:0]    n_count;
  logic [CW-1:0]    cnt_m1, cnt_m3;
  logic             rej;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic             n_error;

  assign cnt_m1 = count_q - CW'(1);
  assign cnt_m3 = count_q - CW'(3);

  always_comb begin
    n_top    = top_q;
    n_second = second_q;
    n_count  = count_q;
    rej      = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = count_q[AW-1:0];
    unique case ({push, pop})
      2'b10: begin
        if (full_q) begin
          rej = 1'b1;
        end else begin
          wr_en    = 1'b1;
          n_count  = count_q + CW'(1);
          n_top    = stack_in;
          n_second = top_q;
        end
      end
      2'b01: begin
        if (empty_q) begin
          rej = 1'b1;
        end else begin
          n_count  = cnt_m1;
          n_top    = second_q;
          // the new second lives two below the old top
          n_second = (count_q >= CW'(3)) ?
                     mem[cnt_m3[AW-1:0]] : '0;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        n_top = stack_in;
        if (empty_q) begin
          wr_idx   = '0;
          n_count  = CW'(1);
          n_second = '0;
        end else begin
          wr_idx = cnt_m1[AW-1:0];
        end
      end
      default: ;
    endcase
  end

`ifdef STACK_STICKY_ERROR_EN
  assign n_error = error_q | rej;
`else
  assign n_error = rej;
`endif

  // storage array is intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= stack_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      top_q    <= '0;
      second_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      top_q    <= n_top;
      second_q <= n_second;
      count_q  <= n_count;
      empty_q  <= (n_count == '0);
      full_q   <= (n_count == CW'(DEPTH));
      error_q  <= n_error;
    end
  end

  assign top    = top_q;
  assign second = second_q;
  assign count  = count_q;
  assign empty  = empty_q;
  assign full   = full_q;
  assign error  = error_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed + randomized checks of stack_unit
// against a queue-based LIFO reference model.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef STACK_STICKY_ERROR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             push, pop;
  logic [WIDTH-1:0] stack_in;
  logic [WIDTH-1:0] top, second;
  logic [CW-1:0]    count;
  logic             empty, full, error;

  int checks   = 0;
  int failures = 0;

  int unsigned m_q[$];
  bit          m_err;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .stack_in(stack_in), .top(top), .second(second),
    .count(count), .empty(empty), .full(full), .error(error)
  );

  always #5 clk = ~clk;

  // model: q[0] is bottom, q[$] is top
  task automatic model_apply(input bit p, input bit o,
                             input int unsigned d, input bit r);
    bit rj;
    rj = 1'b0;
    if (!r) begin
      m_q.delete();
      m_err = 1'b0;
      return;
    end
    if (p && !o) begin
      if (m_q.size() == DEPTH) rj = 1'b1;
      else m_q.push_back(d);
    end else if (!p && o) begin
      if (m_q.size() == 0) rj = 1'b1;
      else void'(m_q.pop_back());
    end else if (p && o) begin
      if (m_q.size() == 0) m_q.push_back(d);
      else m_q[m_q.size()-1] = d;
    end
    m_err = STICKY ? (m_err | rj) : rj;
  endtask

  task automatic step(input bit p, input bit o,
                      input logic [WIDTH-1:0] d, input bit r);
    push = p; pop = o; stack_in = d; reset = r;
    @(posedge clk);
    #1;
    model_apply(p, o, int'(d), r);
    push = 0; pop = 0; reset = 1;
  endtask

  task automatic test_reset;
    push = 1; pop = 0; stack_in = 8'h5A;
    step(1, 0, 8'h5A, 0);
    step(0, 0, 8'h00, 0);
    checks++;
    if (top !== 8'h00 || second !== 8'h00 || count !== '0 ||
        empty !== 1'b1 || full !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset: top=%h second=%h count=%0d empty=%b full=%b error=%b, want 00 00 0 1 0 0",
               top, second, count, empty, full, error);
    end
  endtask

  task automatic test_push_seq;
    step(0, 0, 0, 0);
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h22, 1);
    step(1, 0, 8'h33, 1);
    checks++;
    if (top !== 8'h33 || second !== 8'h22 || count !== CW'(3) ||
        empty !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL push_seq: top=%h second=%h count=%0d empty=%b error=%b, want 33 22 3 0 0",
               top, second, count, empty, error);
    end
  endtask

  task automatic test_pop_to_empty;
    logic [WIDTH-1:0] exp_top [3];
    exp_top[0] = 8'h22; exp_top[1] = 8'h11; exp_top[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h00, 1);
      checks++;
      if (top !== exp_top[i] || count !== CW'(2 - i)) begin
        failures++;
        $display("FAIL pop_%0d: top=%h count=%0d, want %h %0d",
                 i, top, count, exp_top[i], 2 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || second !== 8'h00 || error !== 1'b0) begin
      failures++;
      $display("FAIL pop_empty: empty=%b second=%h error=%b, want 1 00 0",
               empty, second, error);
    end
  endtask

  task automatic test_overflow;
    step(0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) step(1, 0, WIDTH'(i), 1);
    step(1, 0, 8'h99, 1);
    checks++;
    if (full !== 1'b1 || top !== 8'h08 || second !== 8'h07 ||
        count !== CW'(8) || error !== 1'b1) begin
      failures++;
      $display("FAIL overflow: full=%b top=%h second=%h count=%0d error=%b, want 1 08 07 8 1",
               full, top, second, count, error);
    end
    step(0, 0, 0, 1);
    checks++;
    if (error !== STICKY || full !== 1'b1 || top !== 8'h08) begin
      failures++;
      $display("FAIL overflow_after: error=%b full=%b top=%h, want %b 1 08",
               error, full, top, STICKY);
    end
  endtask

  task automatic test_underflow;
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    checks++;
    if (error !== 1'b1 || top !== 8'h00 || count !== '0 ||
        empty !== 1'b1) begin
      failures++;
      $display("FAIL underflow: error=%b top=%h count=%0d empty=%b, want 1 00 0 1",
               error, top, count, empty);
    end
    step(1, 0, 8'h42, 1);
    checks++;
    if (top !== 8'h42 || count !== CW'(1) || error !== STICKY) begin
      failures++;
      $display("FAIL underflow_push: top=%h count=%0d error=%b, want 42 1 %b",
               top, count, error, STICKY);
    end
  endtask

  task automatic test_replace;
    step(0, 0, 0, 0);
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h22, 1);
    step(1, 1, 8'h55, 1);
    checks++;
    if (top !== 8'h55 || second !== 8'h11 || count !== CW'(2) ||
        error !== 1'b0) begin
      failures++;
      $display("FAIL replace: top=%h second=%h count=%0d error=%b, want 55 11 2 0",
               top, second, count, error);
    end
    step(0, 1, 0, 1);
    checks++;
    if (top !== 8'h11 || count !== CW'(1)) begin
      failures++;
      $display("FAIL replace_pop: top=%h count=%0d, want 11 1", top, count);
    end
    step(0, 0, 0, 0);
    step(1, 1, 8'h77, 1);
    checks++;
    if (top !== 8'h77 || count !== CW'(1) || second !== 8'h00 ||
        empty !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL replace_empty: top=%h count=%0d second=%h empty=%b error=%b, want 77 1 00 0 0",
               top, count, second, empty, error);
    end
    for (int i = 2; i <= DEPTH; i++) step(1, 0, WIDTH'(i), 1);
    step(1, 1, 8'hC3, 1);
    checks++;
    if (top !== 8'hC3 || count !== CW'(DEPTH) || full !== 1'b1 ||
        error !== 1'b0 || second !== WIDTH'(DEPTH - 1)) begin
      failures++;
      $display("FAIL replace_full: top=%h count=%0d full=%b error=%b second=%h, want c3 8 1 0 07",
               top, count, full, error, second);
    end
  endtask

  task automatic test_reset_mid;
    step(0, 0, 0, 0);
    step(1, 0, 8'h01, 1);
    step(1, 0, 8'h02, 1);
    step(1, 0, 8'h03, 1);
    step(1, 0, 8'hAA, 0);
    checks++;
    if (count !== '0 || top !== 8'h00 || empty !== 1'b1 ||
        error !== 1'b0 || second !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: count=%0d top=%h empty=%b error=%b second=%h, want 0 00 1 0 00",
               count, top, empty, error, second);
    end
    step(0, 1, 0, 1);
    checks++;
    if (error !== 1'b1 || count !== '0 || top !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_pop: error=%b count=%0d top=%h, want 1 0 00",
               error, count, top);
    end
  endtask

  task automatic test_random;
    int unsigned n;
    logic [WIDTH-1:0] et, es;
    step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      // bias toward pushes in the first half, pops in the second
      n = $urandom_range(99);
      if (i < 300)
        step(n < 55, (n >= 40 && n < 80), WIDTH'($urandom), n != 99);
      else
        step(n < 30, (n >= 20 && n < 85), WIDTH'($urandom), n != 99);
      n  = m_q.size();
      et = (n > 0) ? WIDTH'(m_q[n-1]) : '0;
      es = (n > 1) ? WIDTH'(m_q[n-2]) : '0;
      checks++;
      if (top !== et || second !== es || count !== CW'(n) ||
          empty !== (n == 0) || full !== (n == DEPTH) ||
          error !== m_err) begin
        failures++;
        $display("FAIL random_%0d: top=%h second=%h count=%0d empty=%b full=%b error=%b, want %h %h %0d %b %b %b",
                 i, top, second, count, empty, full, error,
                 et, es, n, n == 0, n == DEPTH, m_err);
      end
    end
  endtask

  initial begin
    reset = 0; push = 0; pop = 0; stack_in = '0;
    m_err = 1'b0;
    test_reset;
    test_push_seq;
    test_pop_to_empty;
    test_overflow;
    test_underflow;
    test_replace;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
